// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The INT_VEC state exists only when FETCH_INT_EN is defined.
package fetch_pkg;

`ifdef FETCH_INT_EN
  typedef enum logic [1:0] {RST_VEC, FETCH, IMM, INT_VEC} fetch_state_e;
`else
  typedef enum logic [1:0] {RST_VEC, FETCH, IMM} fetch_state_e;
`endif

  localparam logic [3:0] OPC_IMM        = 4'd12;
  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR   = 8'h01;
  localparam logic [7:0] NOP            = 8'h00;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] imm;
    logic [7:0] pc_plus1;
    logic       valid;
    logic       int_flag;
  } if_id_t;

  localparam if_id_t IF_ID_NOP = '0;

  function automatic logic is_two_byte(input logic [7:0] opc);
    return opc[7:4] == OPC_IMM;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears to NOP and beats stall; otherwise
// stall holds and the default is to load the new bundle.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_stall,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= IF_ID_NOP;
    end else if (i_flush) begin
      r_q <= IF_ID_NOP;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches 1/2-byte instructions and
// inserts the interrupt pseudo-op when built with FETCH_INT_EN.
module fetch_stage
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic       stall,
  input  logic       flush,
  input  logic       pc_load,
  input  logic [7:0] pc_target,
  input  logic       intr,
  output logic [7:0] instr_out,
  output logic [7:0] imm_out,
  output logic [7:0] pc_plus1_out,
  output logic       valid_out,
  output logic       int_signal_out
);

  fetch_state_e r_state, w_state_d;
  logic [7:0]   r_pc, w_pc_d;
  logic [7:0]   r_opc, w_opc_d;
  logic [7:0]   w_pc_plus1;
  logic         w_hold;
  if_id_t       w_if_id_d, w_if_id_q;

`ifdef FETCH_INT_EN
  logic r_int_pend, w_int_pend_d;
`else
  logic w_unused_intr;
  assign w_unused_intr = intr;
`endif

  assign w_pc_plus1 = r_pc + 8'd1;

  always_comb begin
    imem_addr = r_pc;
    unique case (r_state)
      RST_VEC: imem_addr = RESET_VEC_ADDR;
`ifdef FETCH_INT_EN
      INT_VEC: imem_addr = INT_VEC_ADDR;
`endif
      default: imem_addr = r_pc;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_opc_d   = r_opc;
    w_if_id_d = IF_ID_NOP;
    w_hold    = 1'b0;
`ifdef FETCH_INT_EN
    // Level request is latched every cycle; only taking the interrupt clears it.
    w_int_pend_d = r_int_pend | intr;
`endif
    if (r_state == RST_VEC) begin
      w_pc_d    = imem_data;
      w_state_d = FETCH;
    end else if (pc_load) begin
      w_pc_d    = pc_target;
      w_state_d = FETCH;
    end else if (stall) begin
      w_hold = 1'b1;
    end else begin
      case (r_state)
        FETCH: begin
`ifdef FETCH_INT_EN
          if (r_int_pend) begin
            w_if_id_d.instr    = NOP;
            w_if_id_d.pc_plus1 = r_pc;
            w_if_id_d.valid    = 1'b1;
            w_if_id_d.int_flag = 1'b1;
            w_int_pend_d       = 1'b0;
            w_state_d          = INT_VEC;
          end else
`endif
          if (is_two_byte(imem_data)) begin
            w_opc_d   = imem_data;
            w_pc_d    = w_pc_plus1;
            w_state_d = IMM;
          end else begin
            w_if_id_d.instr    = imem_data;
            w_if_id_d.pc_plus1 = w_pc_plus1;
            w_if_id_d.valid    = 1'b1;
            w_pc_d             = w_pc_plus1;
          end
        end
        IMM: begin
          w_if_id_d.instr    = r_opc;
          w_if_id_d.imm      = imem_data;
          w_if_id_d.pc_plus1 = w_pc_plus1;
          w_if_id_d.valid    = 1'b1;
          w_pc_d             = w_pc_plus1;
          w_state_d          = FETCH;
        end
`ifdef FETCH_INT_EN
        INT_VEC: begin
          w_pc_d    = imem_data;
          w_state_d = FETCH;
        end
`endif
        default: w_state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_VEC;
      r_pc    <= 8'h00;
      r_opc   <= NOP;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_opc   <= w_opc_d;
    end
  end

`ifdef FETCH_INT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_pend <= 1'b0;
    end else begin
      r_int_pend <= w_int_pend_d;
    end
  end
`endif

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_stall (w_hold),
    .i_flush (flush),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign instr_out      = w_if_id_q.instr;
  assign imm_out        = w_if_id_q.imm;
  assign pc_plus1_out   = w_if_id_q.pc_plus1;
  assign valid_out      = w_if_id_q.valid;
  assign int_signal_out = w_if_id_q.int_flag;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 8-bit pipelined core. It sits directly upstream of the decode stage and the ID/EX register, and owns the PC. It loads the reset vector, fetches 1- or 2-byte instructions from the asynchronous-read instruction memory, and inserts the interrupt pseudo-instruction. It delivers a registered IF/ID bundle (opcode, immediate, PC+1, int flag) under stall and flush control from the hazard unit.

## Interface
- Parameters: none; all constants come from `fetch_pkg`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `imem_addr` output 8: instruction-memory read address (combinational).
- `imem_data` input 8: instruction-memory read data, same cycle.
- `stall` input 1: hold PC, state and IF/ID register.
- `flush` input 1: clear IF/ID register to NOP.
- `pc_load` input 1: redirect request from EX (branch/call/ret/rti).
- `pc_target` input 8: redirect address.
- `intr` input 1: external interrupt request, level; latched.
- `instr_out` output 8: opcode byte to ID.
- `imm_out` output 8: second byte of 2-byte instructions, else 0.
- `pc_plus1_out` output 8: address after the instruction; return address for the int pseudo-op.
- `valid_out` output 1: IF/ID holds a real instruction.
- `int_signal_out` output 1: IF/ID holds the interrupt pseudo-op.

## Operation
- Encoding: opcode[7:4], ra[3:2], rb[1:0]. The instruction is 2-byte iff opcode[7:4] == `OPC_IMM` (4'd12).
- FSM states:
  - RST_VEC: `imem_addr`=`RESET_VEC_ADDR` (0). Next cycle PC<=`imem_data`, go to FETCH. `stall` is ignored.
  - FETCH: `imem_addr`=PC.
    - 1-byte opcode: IF/ID <= {opc, imm=0, PC+1, valid=1}, PC<=PC+1.
    - 2-byte opcode: latch opc, PC<=PC+1, go to IMM. IF/ID <= NOP (valid=0).
  - IMM: `imem_addr`=PC. IF/ID <= {latched opc, `imem_data`, PC+1, valid=1}, PC<=PC+1, go to FETCH.
  - INT_VEC: `imem_addr`=`INT_VEC_ADDR` (1). PC<=`imem_data`, go to FETCH. IF/ID <= NOP.
- Interrupt entry: `int_pend` is set when `intr`=1. It is taken only in FETCH, at an instruction boundary, with no `stall` and no `pc_load`. Taking it does not fetch from memory. IF/ID <= {`NOP`, 0, PC, valid=1, int=1}, `int_pend` is cleared, and the FSM goes to INT_VEC.
- Priority per edge: `rst` > `pc_load` > `stall` > normal. `flush` acts on the IF/ID register only and beats `stall` there.
- `pc_load`: PC<=`pc_target`. The FSM goes to FETCH from any state except RST_VEC, abandoning a half-fetched 2-byte instruction. `int_pend` is preserved.
- PC arithmetic is modulo 256: 8'hFF+1=8'h00.
- `NOP`=8'h00.

## Timing
- Reset values: PC=0, state=RST_VEC, `int_pend`=0. All IF/ID outputs are 0, including `valid_out` and `int_signal_out`.
- First instruction appears at the IF/ID outputs 2 edges after `rst` deasserts.
- Throughput: 1-byte instruction, 1 cycle; 2-byte instruction, 2 cycles with a bubble ahead of it. Interrupt entry: 2 cycles (pseudo-op, then vector load).
- Latency: from `imem_data` to IF/ID outputs is one edge.
- `intr` pulse: a 1-cycle pulse is never lost. Re-assertion while `int_pend`=1 is absorbed.
- `rst` mid-operation: immediate return to reset values; the pending interrupt is discarded.
- `pc_load` and `flush` together: redirect plus IF/ID=NOP in the same edge.
- `stall` during IMM: both the latched opcode and PC are held.

## Configuration
- `FETCH_INT_EN` defined: `int_pend`, the INT_VEC state and the pseudo-op are present.
- `FETCH_INT_EN` undefined: `intr` is ignored, `int_signal_out` is tied 0, the INT_VEC state is removed, and FETCH never diverts.

## Structure
- `fetch_pkg` holds:
  - state enum {RST_VEC, FETCH, IMM, INT_VEC};
  - `OPC_IMM`=4'd12;
  - `RESET_VEC_ADDR`=8'h00;
  - `INT_VEC_ADDR`=8'h01;
  - `NOP`=8'h00.
- Sub-module `if_id_reg`: the output register, with stall/flush/load, 26 bits.
- FSM, PC and `int_pend` stay in `fetch_stage`.

## Test plan
- Reset with M[0]=8'h10, M[0x10]=8'h25: after 2 edges, `instr_out`=8'h25, `pc_plus1_out`=8'h11, `valid_out`=1.
- 2-byte instruction: M[0x10]=8'hC4, M[0x11]=8'h7A. The bubble has `valid_out`=0. The next cycle gives `instr_out`=8'hC4, `imm_out`=8'h7A, `pc_plus1_out`=8'h12.
- `pc_load` with `pc_target`=8'h40 while in IMM: the partial fetch is dropped; the next valid instruction is M[0x40] with `pc_plus1_out`=8'h41.
- `stall` held for 3 cycles: IF/ID and PC are unchanged. `stall` with `flush`: `valid_out`=0, `instr_out`=0.
- 1-cycle `intr` pulse with PC=8'h20 and M[1]=8'h80 (`FETCH_INT_EN`): the pseudo-op appears with `int_signal_out`=1 and `pc_plus1_out`=8'h20. The next valid instruction is fetched from 8'h80.
- PC at 8'hFF with a 1-byte instruction: `pc_plus1_out`=8'h00 and the next fetch is from address 0.
